// File: rtl/change_pkg.sv
// Shared types and constants for the sequential change dispenser.
//   state_e       : controller states
//   *_VAL         : default coin values (circle, triangle, pentagon)
//   IDX_*         : default coin type indices into the inventory/value vectors
package change_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CHECK    = 2'd1,
    DISPENSE = 2'd2,
    DONE     = 2'd3
  } state_e;

  localparam int unsigned DEF_VAL_W = 4;

  localparam logic [DEF_VAL_W-1:0] CIRCLE_VAL   = 4'd1;
  localparam logic [DEF_VAL_W-1:0] TRIANGLE_VAL = 4'd3;
  localparam logic [DEF_VAL_W-1:0] PENTAGON_VAL = 4'd5;

  localparam int unsigned IDX_CIRCLE   = 0;
  localparam int unsigned IDX_TRIANGLE = 1;
  localparam int unsigned IDX_PENTAGON = 2;

endpackage

// File: rtl/change_dispenser_seq_coin_selector.sv
// Greedy coin pick: largest-valued coin type that fits in the amount still
// owed and has stock left; on equal values the lower index wins.
//   remaining   : amount still owed
//   inventory   : packed per-type counts, slice i is type i
//   coin_values : packed per-type values, slice i is type i
//   found       : some type qualifies
//   idx         : index of the chosen type (0 when nothing qualifies)
module coin_selector #(
  parameter int unsigned NUM_TYPES = 3,
  parameter int unsigned VAL_W     = 4,
  parameter int unsigned CNT_W     = 2,
  parameter int unsigned IDX_W     = 2
) (
  input  logic [VAL_W-1:0]           remaining,
  input  logic [NUM_TYPES*CNT_W-1:0] inventory,
  input  logic [NUM_TYPES*VAL_W-1:0] coin_values,
  output logic                       found,
  output logic [IDX_W-1:0]           idx
);

  logic [VAL_W-1:0] best_val;

  // Strict '>' keeps the earliest (lowest) index among equal values.
  always_comb begin
    found    = 1'b0;
    idx      = '0;
    best_val = '0;
    for (int i = 0; i < NUM_TYPES; i++) begin
      if ((coin_values[i*VAL_W +: VAL_W] <= remaining) &&
          (inventory[i*CNT_W +: CNT_W] != '0) &&
          (!found || (coin_values[i*VAL_W +: VAL_W] > best_val))) begin
        found    = 1'b1;
        idx      = IDX_W'(i);
        best_val = coin_values[i*VAL_W +: VAL_W];
      end
    end
  end

endmodule

// File: rtl/change_dispenser_seq.sv
// Sequential change machine: latches cost/paid, computes the change owed and
// pays it out one coin per valid/ready handshake from an internal inventory,
// greedy largest-coin-first, capped at MAX_COINS coins per transaction.
//   CLOCK_100, reset_L          : clock, async active-low reset
//   cost, paid, start           : transaction request (IDLE only)
//   load_inv, inv_in            : inventory load (IDLE only, beats start)
//   coin_valid/ready, coin_type : coin payout handshake
//   remaining, busy, done       : progress/status
//   exact_amount, not_enough_change, cough_up_more : result flags
//   inventory                   : current per-type counts
module change_dispenser_seq
  import change_pkg::*;
#(
  parameter int unsigned                   NUM_TYPES   = 3,
  parameter int unsigned                   VAL_W       = 4,
  parameter int unsigned                   CNT_W       = 2,
  parameter logic [NUM_TYPES*VAL_W-1:0]    COIN_VALUES = {PENTAGON_VAL, TRIANGLE_VAL, CIRCLE_VAL},
  parameter int unsigned                   MAX_COINS   = 2
) (
  input  logic                           CLOCK_100,
  input  logic                           reset_L,
  input  logic [VAL_W-1:0]               cost,
  input  logic [VAL_W-1:0]               paid,
  input  logic                           start,
  input  logic                           load_inv,
  input  logic [NUM_TYPES*CNT_W-1:0]     inv_in,
  output logic                           coin_valid,
  input  logic                           coin_ready,
  output logic [$clog2(NUM_TYPES)-1:0]   coin_type,
  output logic [VAL_W-1:0]               remaining,
  output logic                           busy,
  output logic                           done,
  output logic                           exact_amount,
  output logic                           not_enough_change,
  output logic                           cough_up_more,
  output logic [NUM_TYPES*CNT_W-1:0]     inventory
);

  localparam int unsigned IDX_W = $clog2(NUM_TYPES);
  localparam int unsigned CC_W  = $clog2(MAX_COINS + 1);

  state_e                     state_q, state_d;
  logic [VAL_W-1:0]           cost_q, cost_d;
  logic [VAL_W-1:0]           paid_q, paid_d;
  logic [CC_W-1:0]            coin_cnt_q, coin_cnt_d;
  logic [VAL_W-1:0]           remaining_d;
  logic                       coin_valid_d;
  logic [IDX_W-1:0]           coin_type_d;
  logic                       busy_d, done_d;
  logic                       exact_d, nec_d, cough_d;
  logic [NUM_TYPES*CNT_W-1:0] inventory_d;

  logic                       sel_found_c;
  logic [IDX_W-1:0]           sel_idx_c;

  coin_selector #(
    .NUM_TYPES (NUM_TYPES),
    .VAL_W     (VAL_W),
    .CNT_W     (CNT_W),
    .IDX_W     (IDX_W)
  ) u_sel (
    .remaining   (remaining),
    .inventory   (inventory),
    .coin_values (COIN_VALUES),
    .found       (sel_found_c),
    .idx         (sel_idx_c)
  );

  // State and registered outputs.
  always_ff @(posedge CLOCK_100 or negedge reset_L) begin
    if (!reset_L) begin
      state_q           <= IDLE;
      cost_q            <= '0;
      paid_q            <= '0;
      coin_cnt_q        <= '0;
      remaining         <= '0;
      coin_valid        <= 1'b0;
      coin_type         <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      exact_amount      <= 1'b0;
      not_enough_change <= 1'b0;
      cough_up_more     <= 1'b0;
      inventory         <= '0;
    end else begin
      state_q           <= state_d;
      cost_q            <= cost_d;
      paid_q            <= paid_d;
      coin_cnt_q        <= coin_cnt_d;
      remaining         <= remaining_d;
      coin_valid        <= coin_valid_d;
      coin_type         <= coin_type_d;
      busy              <= busy_d;
      done              <= done_d;
      exact_amount      <= exact_d;
      not_enough_change <= nec_d;
      cough_up_more     <= cough_d;
      inventory         <= inventory_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    cost_d       = cost_q;
    paid_d       = paid_q;
    coin_cnt_d   = coin_cnt_q;
    remaining_d  = remaining;
    coin_valid_d = coin_valid;
    coin_type_d  = coin_type;
    exact_d      = exact_amount;
    nec_d        = not_enough_change;
    cough_d      = cough_up_more;
    inventory_d  = inventory;

    unique case (state_q)
      IDLE: begin
        if (load_inv) begin
          inventory_d = inv_in;
        end else if (start) begin
          cost_d  = cost;
          paid_d  = paid;
          exact_d = 1'b0;
          nec_d   = 1'b0;
          cough_d = 1'b0;
          state_d = CHECK;
        end
      end

      CHECK: begin
        coin_cnt_d = '0;
        if (paid_q < cost_q) begin
          cough_d     = 1'b1;
          remaining_d = '0;
          state_d     = DONE;
        end else if (paid_q == cost_q) begin
          exact_d     = 1'b1;
          remaining_d = '0;
          state_d     = DONE;
        end else begin
          remaining_d = paid_q - cost_q;
          state_d     = DISPENSE;
        end
      end

      DISPENSE: begin
        if (coin_valid) begin
          // Hold the presented coin until it is taken; then spend a cycle
          // with valid low so the selector sees the updated totals.
          if (coin_ready) begin
            coin_valid_d = 1'b0;
            coin_cnt_d   = coin_cnt_q + CC_W'(1);
            for (int i = 0; i < NUM_TYPES; i++) begin
              if (coin_type == IDX_W'(i)) begin
                inventory_d[i*CNT_W +: CNT_W] = inventory[i*CNT_W +: CNT_W] - CNT_W'(1);
                remaining_d = remaining - COIN_VALUES[i*VAL_W +: VAL_W];
              end
            end
          end
        end else if (sel_found_c && (remaining != '0) && (coin_cnt_q < CC_W'(MAX_COINS))) begin
          coin_valid_d = 1'b1;
          coin_type_d  = sel_idx_c;
        end else begin
          nec_d   = (remaining != '0);
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == CHECK) || (state_d == DISPENSE);
    done_d = (state_d == DONE);
  end

endmodule
